// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: RTC transaction sequencer (init writes, periodic 6-register burst reads, user writes); final is reserved, so the handshake input is final_tx
module secuenciador_rtc #(
  parameter int unsigned PERIODO = 1_000_000,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [7:0] DIR_INIT = 8'h02,
  parameter logic [7:0] INIT_D0 = 8'h10,
  parameter logic [7:0] INIT_D1 = 8'h00,
  parameter logic [7:0] DIR_BASE = 8'h21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       final_tx,
  input  logic [7:0] dato_leido,
  output logic       iniciar,
  output logic       escribe,
  output logic [7:0] direccion,
  output logic [7:0] dato,
  output logic       esc,
  input  logic       req_esc,
  input  logic [7:0] dir_usr,
  input  logic [7:0] dato_usr,
  output logic       ocupado,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       actualizado,
  output logic       error_to
);
  localparam int TW = $clog2(PERIODO);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {INIT0, INIT1, IDLE, USR_WR, LECT} st_t;
  typedef enum logic [1:0] {ARRANQUE, ESPERA, PAUSA} fase_t;
  st_t st_q, st_d;
  fase_t fase_q, fase_d;
  logic [2:0] k_q, k_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic p_q, p_d, abort_q, abort_d, slot_q, slot_d, ref_q, ref_d;
  logic [7:0] udir_q, udir_d, udat_q, udat_d, dir_q, dir_d, dato_q, dato_d;
  logic [7:0] sh_q [6], sh_d [6], snap_q [6], snap_d [6];
  logic iniciar_q, iniciar_d, escribe_q, escribe_d, esc_q, esc_d, act_q, act_d, err_q, err_d;
  logic wrap, to, activo, load, fin, commit;
  assign wrap = tmr_q == TW'(PERIODO - 1);
  assign to = wd_q == WW'(TIMEOUT - 1);
  assign activo = st_q != IDLE;
  assign load = activo && fase_q == ARRANQUE;
  assign fin = activo && fase_q == PAUSA && p_q;
  assign commit = fin && st_q == LECT && !abort_q && k_q == 3'd5;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= INIT0;
      fase_q <= ARRANQUE;
      k_q <= '0;
      wd_q <= '0;
      tmr_q <= '0;
      p_q <= 1'b0;
      abort_q <= 1'b0;
      slot_q <= 1'b0;
      ref_q <= 1'b0;
      udir_q <= '0;
      udat_q <= '0;
      dir_q <= '0;
      dato_q <= '0;
      sh_q <= '{default: '0};
      snap_q <= '{default: '0};
      iniciar_q <= 1'b0;
      escribe_q <= 1'b0;
      esc_q <= 1'b0;
      act_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      fase_q <= fase_d;
      k_q <= k_d;
      wd_q <= wd_d;
      tmr_q <= tmr_d;
      p_q <= p_d;
      abort_q <= abort_d;
      slot_q <= slot_d;
      ref_q <= ref_d;
      udir_q <= udir_d;
      udat_q <= udat_d;
      dir_q <= dir_d;
      dato_q <= dato_d;
      sh_q <= sh_d;
      snap_q <= snap_d;
      iniciar_q <= iniciar_d;
      escribe_q <= escribe_d;
      esc_q <= esc_d;
      act_q <= act_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    st_d = st_q;
    fase_d = fase_q;
    k_d = k_q;
    wd_d = wd_q;
    p_d = p_q;
    abort_d = abort_q;
    sh_d = sh_q;
    tmr_d = wrap ? '0 : tmr_q + 1'b1;
    ref_d = ref_q | wrap;
    slot_d = slot_q | req_esc;
    udir_d = (req_esc && !slot_q) ? dir_usr : udir_q;
    udat_d = (req_esc && !slot_q) ? dato_usr : udat_q;
    if (!activo) begin
      fase_d = ARRANQUE;
      k_d = '0;
      if (slot_q) st_d = USR_WR;
      else if (ref_q) begin
        st_d = LECT;
        ref_d = wrap;
      end
    end else begin
      case (fase_q)
        ARRANQUE: begin
          fase_d = ESPERA;
          wd_d = '0;
          abort_d = 1'b0;
        end
        ESPERA: begin
          if (final_tx) begin
            fase_d = PAUSA;
            p_d = 1'b0;
            if (st_q == LECT) sh_d[k_q] = dato_leido;
          end else if (to) begin
            fase_d = PAUSA;
            p_d = 1'b0;
            abort_d = 1'b1;
          end else wd_d = wd_q + 1'b1;
        end
        default: begin
          p_d = 1'b1;
          if (p_q) begin
            fase_d = ARRANQUE;
            case (st_q)
              INIT0: st_d = abort_q ? INIT0 : INIT1;
              INIT1: begin
                st_d = abort_q ? INIT0 : IDLE;
                ref_d = !abort_q || ref_d;
              end
              USR_WR: begin
                st_d = IDLE;
                slot_d = 1'b0;
              end
              default: begin
                st_d = (abort_q || k_q == 3'd5) ? IDLE : LECT;
                k_d = k_q + 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end
  always_comb begin
    iniciar_d = load || (activo && fase_q == ESPERA && !final_tx && !to);
    escribe_d = load ? st_q != LECT : escribe_q;
    dir_d = load ? (st_q == LECT ? DIR_BASE + {5'd0, k_q} : st_q == USR_WR ? udir_q : DIR_INIT) : dir_q;
    dato_d = load ? (st_q == LECT ? 8'h00 : st_q == USR_WR ? udat_q : st_q == INIT0 ? INIT_D0 : INIT_D1) : dato_q;
    esc_d = activo && (load ? st_q == LECT : esc_q);
    act_d = commit;
    err_d = activo && fase_q == ESPERA && !final_tx && to;
    snap_d = snap_q;
    if (commit) snap_d = sh_q;
  end
  assign iniciar = iniciar_q;
  assign escribe = escribe_q;
  assign direccion = dir_q;
  assign dato = dato_q;
  assign esc = esc_q;
  assign ocupado = slot_q;
  assign actualizado = act_q;
  assign error_to = err_q;
  assign segundos = snap_q[0];
  assign minutos = snap_q[1];
  assign horas = snap_q[2];
  assign dia = snap_q[3];
  assign mes = snap_q[4];
  assign anio = snap_q[5];
endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb_secuenciador_rtc: randomized bench with an RTC register-file model answering the handshake
module tb_secuenciador_rtc;
  localparam int PER = 3000;
  logic clk = 1'b0, reset = 1'b1, final_tx = 1'b0, req_esc = 1'b0;
  logic [7:0] dato_leido = '0, dir_usr = '0, dato_usr = '0;
  logic iniciar, escribe, esc, ocupado, actualizado, error_to;
  logic [7:0] direccion, dato, segundos, minutos, horas, dia, mes, anio;
  logic [7:0] mem [256];
  logic [7:0] rd [6];
  logic [17:0] obs [$];
  int checks = 0, errors = 0;
  int lat = 29, mudo = -1, last_len = 0, n_act = 0, n_err = 0;
  wire [47:0] snap = {anio, mes, dia, horas, minutos, segundos};

  secuenciador_rtc #(.PERIODO(PER), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .final_tx(final_tx), .dato_leido(dato_leido),
    .iniciar(iniciar), .escribe(escribe), .direccion(direccion), .dato(dato), .esc(esc),
    .req_esc(req_esc), .dir_usr(dir_usr), .dato_usr(dato_usr), .ocupado(ocupado),
    .segundos(segundos), .minutos(minutos), .horas(horas), .dia(dia), .mes(mes), .anio(anio),
    .actualizado(actualizado), .error_to(error_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RTC register file answering each transaction after lat cycles, final held 2 cycles
  initial begin
    int cnt = 0, hold = 0, ntx = 0;
    logic [7:0] off;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          final_tx = 1'b0;
          cnt = 0;
          ntx++;
          if (ntx >= 8) lat = $urandom_range(20, 40);
        end
      end else if (!iniciar) cnt = 0;
      else begin
        cnt++;
        if (cnt == lat && !(mudo == int'(direccion) && !escribe)) begin
          final_tx = 1'b1;
          hold = 2;
          if (escribe) begin
            mem[direccion] = dato;
            dato_leido = 8'h00;
          end else begin
            dato_leido = mem[direccion];
            off = direccion - 8'h21;
            if (off < 8'd6) rd[off[2:0]] = mem[direccion];
          end
        end
      end
    end
  end

  initial begin
    logic prev_ini = 1'b0, prev_rst = 1'b1, inest = 1'b0;
    int hi = 0, lo = 99;
    logic [47:0] prev_snap = '0;
    logic [17:0] cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lo = 99;
        hi = 0;
      end else if (iniciar && !prev_ini) begin
        chk("gap", lo >= 2, 1);
        cur = {escribe, direccion, dato, esc};
        obs.push_back(cur);
        hi = 1;
        inest = 1'b0;
      end else if (iniciar) begin
        hi++;
        if (cur != {escribe, direccion, dato, esc}) inest = 1'b1;
      end else if (prev_ini) begin
        last_len = hi;
        chk("stable", inest, 0);
        lo = prev_rst ? 99 : 1;
      end else lo++;
      if (actualizado) begin
        n_act++;
        chk("snap", snap, {rd[5], rd[4], rd[3], rd[2], rd[1], rd[0]});
      end
      if (error_to) n_err++;
      if (snap != prev_snap && !prev_rst) chk("atomic", actualizado, 1);
      prev_ini = iniciar;
      prev_rst = reset;
      prev_snap = snap;
    end
  end

  task automatic expect_tx(input string tag, input logic w, input logic [7:0] d, input logic [7:0] v, input logic e);
    logic [17:0] t;
    for (int i = 0; i < 5000 && obs.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    t = obs.size() > 0 ? obs.pop_front() : '1;
    chk(tag, t, {w, d, v, e});
  endtask

  task automatic wait_act(input int target);
    for (int i = 0; i < 4000 && n_act < target; i++) @(negedge clk);
    chk("act_count", n_act, target);
  endtask

  task automatic user_req(input logic [7:0] d, input logic [7:0] v);
    @(posedge clk); #1;
    req_esc = 1'b1;
    dir_usr = d;
    dato_usr = v;
    @(posedge clk); #1;
    req_esc = 1'b0;
  endtask

  task automatic wait_fall();
    for (int i = 0; i < 500 && iniciar; i++) @(negedge clk);
    chk("fall", iniciar, 0);
  endtask

  task automatic burst(input string tag, input int n);
    for (int k = 0; k < n; k++) expect_tx(tag, 1'b0, 8'h21 + 8'(k), 8'h00, 1'b1);
  endtask

  initial begin
    logic [47:0] s0;
    logic [7:0] d, v;
    int na;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) rd[i] = '0;
    mem[8'h21] = 8'h59; mem[8'h22] = 8'h59; mem[8'h23] = 8'h23;
    mem[8'h24] = 8'h31; mem[8'h25] = 8'h12; mem[8'h26] = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {iniciar, escribe, direccion, dato, esc, ocupado, actualizado, error_to}, 0);
    chk("rst_snap", snap, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    expect_tx("init0", 1'b1, 8'h02, 8'h10, 1'b0);
    expect_tx("init1", 1'b1, 8'h02, 8'h00, 1'b0);
    burst("lect_t1", 6);
    wait_act(1);
    chk("t2_snap", snap, 48'h99_12_31_23_59_59);
    for (int i = 0; i < 6; i++) mem[8'h21 + i] = 8'($urandom);
    burst("lect_t3", 3);
    user_req(8'h23, 8'h08);
    @(negedge clk);
    chk("ocup_set", ocupado, 1);
    user_req(8'($urandom), 8'($urandom));
    burst("lect_t3b", 0);
    for (int k = 3; k < 6; k++) expect_tx("lect_t3", 1'b0, 8'h21 + 8'(k), 8'h00, 1'b1);
    wait_act(2);
    expect_tx("usr_t3", 1'b1, 8'h23, 8'h08, 1'b0);
    chk("ocup_busy", ocupado, 1);
    wait_fall();
    chk("ocup_p1", ocupado, 1);
    @(negedge clk);
    chk("ocup_p2", ocupado, 1);
    @(negedge clk);
    chk("ocup_free", ocupado, 0);
    repeat (100) @(negedge clk);
    chk("no_extra", obs.size(), 0);
    for (int r = 0; r < 3; r++) begin
      d = 8'($urandom);
      v = 8'($urandom);
      user_req(d, v);
      expect_tx("usr_rnd", 1'b1, d, v, 1'b0);
      for (int i = 0; i < 300 && ocupado; i++) @(negedge clk);
      chk("usr_done", ocupado, 0);
    end
    s0 = snap;
    na = n_act;
    mudo = 'h24;
    burst("lect_t4", 4);
    wait_fall();
    chk("to_len", last_len, 64);
    repeat (50) @(negedge clk);
    chk("to_pulse", n_err, 1);
    chk("no_act", n_act, na);
    chk("snap_kept", snap, s0);
    chk("no_more_tx", obs.size(), 0);
    mudo = -1;
    d = 8'($urandom);
    v = 8'($urandom);
    user_req(d, v);
    expect_tx("usr_t6", 1'b1, d, v, 1'b0);
    repeat (10) @(negedge clk);
    chk("t6_espera", iniciar, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst6_bus", {iniciar, escribe, direccion, dato, esc, ocupado, actualizado, error_to}, 0);
    chk("rst6_snap", snap, 0);
    expect_tx("init0_t6", 1'b1, 8'h02, 8'h10, 1'b0);
    expect_tx("init1_t6", 1'b1, 8'h02, 8'h00, 1'b0);
    burst("lect_t6", 6);
    wait_act(na + 1);
    chk("err_total", n_err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
